// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing, derived
// constants, the invalid-coordinate code and a small range helper.
package vga_pkg;

  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BACK_DEF   = 48;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FRONT_DEF  = 16;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BACK_DEF   = 33;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FRONT_DEF  = 10;

  localparam int unsigned H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;
  localparam int unsigned V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;

  // Visible window (rgb_valid) and request window (one clock earlier).
  localparam int unsigned H_VIS_LO_DEF = H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned H_VIS_HI_DEF = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF - 1;
  localparam int unsigned H_REQ_LO_DEF = H_VIS_LO_DEF - 1;
  localparam int unsigned H_REQ_HI_DEF = H_VIS_HI_DEF - 1;
  localparam int unsigned V_VIS_LO_DEF = V_SYNC_DEF + V_BACK_DEF;
  localparam int unsigned V_VIS_HI_DEF = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF - 1;

  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] COORD_INVALID = 10'h3FF;

  // Raster position: horizontal and vertical counters.
  typedef struct packed {
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } vga_pos_t;

  // Inclusive range test on 10-bit counter values.
  function automatic logic in_range(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_ctrl.sv
// VGA timing generator: free-running h/v counters, sync/visible decode,
// pixel request coordinates one clock ahead of the visible window, and
// a registered frame_start pulse after each frame wrap.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BACK   = H_BACK_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FRONT  = H_FRONT_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BACK   = V_BACK_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FRONT  = V_FRONT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] H_REQ_LO = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_HI = 10'(H_SYNC + H_BACK + H_ACTIVE - 2);
  localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);

  vga_pos_t pos_q, pos_d;
  logic     frame_start_q, frame_start_d;
  logic     h_vis, h_req, v_vis;

  // Next raster position; v advances only on the last clock of a line,
  // and a frame wrap arms frame_start for the following cycle.
  always_comb begin
    pos_d         = pos_q;
    frame_start_d = 1'b0;
    if (pos_q.h == H_LAST) begin
      pos_d.h = 10'd0;
      if (pos_q.v == V_LAST) begin
        pos_d.v       = 10'd0;
        frame_start_d = 1'b1;
      end else begin
        pos_d.v = pos_q.v + 10'd1;
      end
    end else begin
      pos_d.h = pos_q.h + 10'd1;
    end
  end

  // Counter and frame_start registers with synchronous reset to (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      pos_q         <= pos_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Sync, window and request-coordinate decode from the registered counters.
  always_comb begin
    h_vis     = in_range(pos_q.h, H_VIS_LO, H_VIS_HI);
    h_req     = in_range(pos_q.h, H_REQ_LO, H_REQ_HI);
    v_vis     = in_range(pos_q.v, V_VIS_LO, V_VIS_HI);
    hsync     = (pos_q.h >= H_SYNC_W);
    vsync     = (pos_q.v >= V_SYNC_W);
    rgb_valid = h_vis && v_vis;
    if (h_req && v_vis) begin
      pix_x = pos_q.h - H_REQ_LO;
      pix_y = pos_q.v - V_VIS_LO;
    end else begin
      pix_x = COORD_INVALID;
      pix_y = COORD_INVALID;
    end
    if (rgb_valid) begin
      rgb = pix_data;
    end else begin
      rgb = 16'h0000;
    end
    frame_start = frame_start_q;
  end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter H_SYNC, default 96, meaning horizontal sync pulse width in clocks.
REQ-002 Parameter H_BACK, default 48, meaning horizontal back porch in clocks.
REQ-003 Parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-004 Parameter H_FRONT, default 16, meaning horizontal front porch in clocks.
REQ-005 Parameter V_SYNC, default 2, meaning vertical sync pulse width in lines.
REQ-006 Parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-007 Parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-008 Parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-009 clk  input  1  pixel clock (25 MHz); one clock for the whole block.
REQ-010 rst  input  1  reset, synchronous and active-high.
REQ-011 pix_data  input  16  RGB565 pixel from the downstream image block; one-cycle registered latency after pix_x/pix_y.
REQ-012 pix_x  output  10  requested pixel column, or 10'h3FF when no request.
REQ-013 pix_y  output  10  requested pixel row, or 10'h3FF when no request.
REQ-014 hsync  output  1  horizontal sync, active-low.
REQ-015 vsync  output  1  vertical sync, active-low.
REQ-016 rgb_valid  output  1  high while the display is in the visible area.
REQ-017 rgb  output  16  RGB565 to the DAC, zero outside the visible area.
REQ-018 frame_start  output  1  one-cycle pulse at the first clock of each frame after a wrap.

Function
REQ-019 Horizontal counter h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800), wrapping to 0.
REQ-020 Vertical counter v_cnt SHALL increment only when h_cnt = H_TOTAL-1, counting 0..V_TOTAL-1 (525), wrapping to 0 on the same edge h_cnt wraps at v_cnt = V_TOTAL-1.
REQ-021 hsync SHALL be 0 for h_cnt in [0, H_SYNC-1] and 1 otherwise.
REQ-022 vsync SHALL be 0 for v_cnt in [0, V_SYNC-1] and 1 otherwise.
REQ-023 Visible area is h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] = [144, 783] AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1] = [35, 514].
REQ-024 rgb_valid SHALL be 1 exactly in the visible area.
REQ-025 The request window is the visible area shifted one clock earlier horizontally: h_cnt in [143, 782], same v_cnt range.
REQ-026 Inside the request window, pix_x SHALL equal h_cnt-143 (0..639) and pix_y SHALL equal v_cnt-35 (0..479); outside it, both SHALL be 10'h3FF.
REQ-027 rgb SHALL equal pix_data when rgb_valid = 1 and 16'h0000 otherwise, so that screen column N shows the image block's response to pix_x = N.
REQ-028 frame_start SHALL be a register set to 1 in the cycle after h_cnt = 799 and v_cnt = 524, and 0 in every other cycle.
REQ-029 All counter arithmetic SHALL use 10-bit unsigned widths; the subtractions in REQ-026 never underflow inside the window.
REQ-030 pix_x, pix_y, hsync, vsync, rgb_valid and rgb SHALL be decoded from registered counters only, with no dependence on input timing other than pix_data.

Reset
REQ-031 While rst = 1 at a clk edge, h_cnt, v_cnt and frame_start SHALL be cleared to 0.
REQ-032 Consequently, during and directly after reset: hsync = 0, vsync = 0, rgb_valid = 0, rgb = 0, pix_x = pix_y = 10'h3FF, frame_start = 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; counting restarts at (0,0) on the first edge with rst = 0, and no frame_start pulse is issued for that restart.

Structure
REQ-034 Timing defaults and derived constants (H_TOTAL, V_TOTAL, window bounds, 10'h3FF invalid code) SHALL live in the shared package vga_pkg, which the image block also uses.
REQ-035 The counters and decode SHALL be flat in vga_ctrl; no sub-module is required.

Verification
REQ-036 Release reset, then count clocks: hsync falls every 800 clocks with low width 96; vsync low width is exactly 2 × 800 = 1600 clocks per 420000-clock frame.
REQ-037 At h_cnt = 143, v_cnt = 35: pix_x = 0 and pix_y = 0. At h_cnt = 782, v_cnt = 514: pix_x = 639 and pix_y = 479. At h_cnt = 142 or 783: pix_x = 10'h3FF.
REQ-038 Connect a model returning pix_data = {pix_x[9:4], pix_y[9:0]} with one-cycle registered latency: every rgb_valid cycle shows rgb matching the (x, y) of that screen position; rgb = 0 when rgb_valid = 0.
REQ-039 Run two full frames: frame_start pulses exactly once, one clock after (799, 524), and is absent after the initial reset.
REQ-040 Assert rst for 3 clocks at h_cnt = 400, v_cnt = 200: the outputs take their reset values, and after release hsync stays low for 96 clocks starting from h_cnt = 0.
REQ-041 Override with H_ACTIVE = 8, V_ACTIVE = 4 (smaller totals): the windows, pix_x range 0..7 and wrap points track the new parameters.
